reg_bank_decoder: RTL

REG_BANK_DECODER -- requirements
Module: reg_bank_decoder

---
 rtl/reg_dec_pkg.sv | 16 +
 rtl/reg_addr_match.sv | 28 ++
 rtl/reg_bank_decoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/reg_dec_pkg.sv
// Shared types and helpers for the register-bank decoder.
// Optional miss-reporting feature is controlled by macro REG_DEC_ERR_EN.
package reg_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Register-index width; at least one bit so a single-register bank stays legal.
  function automatic int unsigned IDX_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_addr_match.sv
// Combinational address window compare and register index generation.
module reg_addr_match
  import reg_dec_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned A_WIDTH   = 8,
  localparam int unsigned IW       = IDX_W(NUM_REGS)
) (
  input  logic [A_WIDTH-1:0] addr,
  output logic               hit,
  output logic [IW-1:0]      idx
);

  // One extra bit keeps BASE_ADDR+NUM_REGS from wrapping at the top of the map.
  localparam int unsigned CW = A_WIDTH + 1;
  localparam logic [CW-1:0] LO = CW'(BASE_ADDR);
  localparam logic [CW-1:0] HI = CW'(BASE_ADDR + NUM_REGS);

  logic [CW-1:0] ext;

  always_comb begin
    ext = {1'b0, addr};
    hit = (ext >= LO) && (ext < HI);
    idx = IW'(ext - LO);
  end

endmodule

// File: rtl/reg_bank_decoder.sv
// Request/ack register-bank decoder: one registered ack per sel_en assertion.
// Define REG_DEC_ERR_EN to add the err port and acknowledge unmapped accesses.
module reg_bank_decoder
  import reg_dec_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned A_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sel_en,
  input  logic                        wr_rd_s,
  input  logic [A_WIDTH-1:0]          addr,
  input  logic [NUM_REGS*W_WIDTH-1:0] reg_rd_data_in,
  output logic [NUM_REGS-1:0]         wr_en,
  output logic [W_WIDTH-1:0]          rd_data,
  output logic                        ack
`ifdef REG_DEC_ERR_EN
  ,
  output logic                        err
`endif
);

  localparam int unsigned IW = IDX_W(NUM_REGS);

  state_t              state_q, state_d;
  logic                hit;
  logic [IW-1:0]       idx;
  logic [NUM_REGS-1:0] wr_en_d;
  logic [W_WIDTH-1:0]  rd_data_d;
  logic                ack_d;
`ifdef REG_DEC_ERR_EN
  logic                err_d;
`endif

  reg_addr_match #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .A_WIDTH   (A_WIDTH)
  ) u_match (
    .addr (addr),
    .hit  (hit),
    .idx  (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The whole transaction is decoded at the capture edge, so later addr/wr_rd_s
  // changes cannot affect it and RESP outputs come straight from registers.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = '0;
    rd_data_d = '0;
    ack_d     = 1'b0;
`ifdef REG_DEC_ERR_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_en) begin
          state_d = RESP;
          if (hit) begin
            ack_d = 1'b1;
            if (wr_rd_s) wr_en_d   = NUM_REGS'(1) << idx;
            else         rd_data_d = reg_rd_data_in[idx*W_WIDTH +: W_WIDTH];
          end
`ifdef REG_DEC_ERR_EN
          else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
`endif
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    if (!sel_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      rd_data <= '0;
      ack     <= 1'b0;
`ifdef REG_DEC_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      wr_en   <= wr_en_d;
      rd_data <= rd_data_d;
      ack     <= ack_d;
`ifdef REG_DEC_ERR_EN
      err     <= err_d;
`endif
    end
  end

endmodule
